// File: rtl/svnet_pkg.sv
// Shared helpers for the svnet pooling/unpooling blocks: index sizing and a
// signed compare used by both the pooling tree and the unpooler.
package svnet_pkg;

    // Compare width; lane data is sign-extended to this before comparing.
    localparam int unsigned SVNET_CMP_W = 64;

    function automatic int unsigned svnet_idx_width(input int unsigned count);
        return (count == 1) ? 1 : $clog2(count);
    endfunction

    // Strictly greater, so a scan from lane 0 keeps the lowest index on ties.
    function automatic logic svnet_signed_gt(input logic signed [SVNET_CMP_W-1:0] a,
                                             input logic signed [SVNET_CMP_W-1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/svnet_index_fifo.sv
// Small synchronous FIFO holding argmax lane indices between the forward
// (push) and backward (pop) sides; head is read combinationally.
module svnet_index_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [IDX_W-1:0]           i_push_idx,
    input  logic                       i_pop,
    output logic [IDX_W-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [LvlW-1:0]  r_level;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_push && r_level == LvlW'(DEPTH)))
                else $error("svnet_index_fifo: push while full");
            assert (!(i_pop && r_level == '0))
                else $error("svnet_index_fifo: pop while empty");
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/svnet_max_unpool.sv
// Max-pool forward path that records argmax lanes, plus the backward path that
// scatters each gradient value back onto its recorded lane.
module svnet_max_unpool
    import svnet_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned COUNT = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_fwd_valid,
    input  logic [COUNT-1:0][WIDTH-1:0]  i_fwd_data,
    output logic                         o_fwd_ready,
    output logic                         o_max_valid,
    output logic [WIDTH-1:0]             o_max_data,
    input  logic                         i_bwd_valid,
    input  logic [WIDTH-1:0]             i_bwd_data,
    output logic                         o_bwd_ready,
    output logic                         o_bwd_valid,
    output logic [COUNT-1:0][WIDTH-1:0]  o_bwd_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int unsigned IdxW = svnet_idx_width(COUNT);
    localparam int unsigned LvlW = $clog2(DEPTH + 1);

    logic                        r_s1_valid;
    logic [COUNT-1:0][WIDTH-1:0] r_s1_data;
    logic                        r_max_valid;
    logic [WIDTH-1:0]            r_max_data;
    logic                        r_bwd_valid;
    logic [COUNT-1:0][WIDTH-1:0] r_bwd_data;

    logic                        w_fwd_fire;
    logic                        w_bwd_fire;
    logic [IdxW-1:0]             w_head;
    logic [IdxW-1:0]             w_best_idx;
    logic [WIDTH-1:0]            w_best;
    logic [LvlW-1:0]             w_level;
    logic [LvlW:0]               w_occupancy;
    logic [COUNT-1:0][WIDTH-1:0] w_scatter;

    // A pop on the same edge is not credited, so ready is conservative.
    assign w_occupancy = {1'b0, w_level} + (LvlW + 1)'(r_s1_valid);
    assign o_fwd_ready = w_occupancy < (LvlW + 1)'(DEPTH);
    assign o_bwd_ready = (w_level != '0);
    assign w_fwd_fire  = i_fwd_valid && o_fwd_ready;
    assign w_bwd_fire  = i_bwd_valid && o_bwd_ready;

    always_comb begin
        w_best     = r_s1_data[0];
        w_best_idx = '0;
        for (int i = 1; i < int'(COUNT); i++) begin
            if (svnet_signed_gt(SVNET_CMP_W'($signed(r_s1_data[i])),
                                SVNET_CMP_W'($signed(w_best)))) begin
                w_best     = r_s1_data[i];
                w_best_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        w_scatter         = '0;
        w_scatter[w_head] = i_bwd_data;
    end

    svnet_index_fifo #(
        .DEPTH (DEPTH),
        .IDX_W (IdxW)
    ) u_index_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (r_s1_valid),
        .i_push_idx (w_best_idx),
        .i_pop      (w_bwd_fire),
        .o_head     (w_head),
        .o_level    (w_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_max_valid <= 1'b0;
            r_max_data  <= '0;
            r_bwd_valid <= 1'b0;
            r_bwd_data  <= '0;
        end else begin
            r_s1_valid  <= w_fwd_fire;
            r_max_valid <= r_s1_valid;
            r_bwd_valid <= w_bwd_fire;
            if (w_fwd_fire) r_s1_data  <= i_fwd_data;
            if (r_s1_valid) r_max_data <= w_best;
            if (w_bwd_fire) r_bwd_data <= w_scatter;
        end
    end

    assign o_max_valid = r_max_valid;
    assign o_max_data  = r_max_data;
    assign o_bwd_valid = r_bwd_valid;
    assign o_bwd_data  = r_bwd_data;
    assign o_level     = w_level;

endmodule

// File: tb/tb_svnet_max_unpool.sv
// Directed bench for svnet_max_unpool: reset, argmax/scatter, full FIFO,
// simultaneous push/pop and mid-operation reset.
module tb_svnet_max_unpool;

    logic            clk = 1'b0;
    logic            rst;
    logic            fwd_valid;
    logic [3:0][7:0] fwd_data;
    logic            fwd_ready;
    logic            max_valid;
    logic [7:0]      max_data;
    logic            bwd_valid_in;
    logic [7:0]      bwd_data_in;
    logic            bwd_ready;
    logic            bwd_valid;
    logic [3:0][7:0] bwd_data;
    logic [2:0]      level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    svnet_max_unpool #(
        .WIDTH (8),
        .COUNT (4),
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_fwd_valid (fwd_valid),
        .i_fwd_data  (fwd_data),
        .o_fwd_ready (fwd_ready),
        .o_max_valid (max_valid),
        .o_max_data  (max_data),
        .i_bwd_valid (bwd_valid_in),
        .i_bwd_data  (bwd_data_in),
        .o_bwd_ready (bwd_ready),
        .o_bwd_valid (bwd_valid),
        .o_bwd_data  (bwd_data),
        .o_level     (level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic win(input logic [7:0] l0, input logic [7:0] l1,
                       input logic [7:0] l2, input logic [7:0] l3);
        fwd_data = {l3, l2, l1, l0};
    endtask

    initial begin
        rst          = 1'b1;
        fwd_valid    = 1'b0;
        fwd_data     = '0;
        bwd_valid_in = 1'b0;
        bwd_data_in  = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_fwd_ready", 32'(fwd_ready), 32'd1);
        check("rst_bwd_ready", 32'(bwd_ready), 32'd0);
        check("rst_level",     32'(level),     32'd0);
        check("rst_max_valid", 32'(max_valid), 32'd0);
        check("rst_bwd_valid", 32'(bwd_valid), 32'd0);
        check("rst_max_data",  32'(max_data),  32'd0);
        check("rst_bwd_data",  32'(bwd_data),  32'd0);

        // Basic: max 0x7F on lane 2
        win(8'h05, 8'hFD, 8'h7F, 8'h10);
        fwd_valid = 1'b1;
        tick();
        fwd_valid = 1'b0;
        check("basic_c1_max_valid", 32'(max_valid), 32'd0);
        tick();
        check("basic_max_valid", 32'(max_valid), 32'd1);
        check("basic_max_data",  32'(max_data),  32'h7F);
        check("basic_level",     32'(level),     32'd1);
        check("basic_bwd_ready", 32'(bwd_ready), 32'd1);
        tick();
        check("basic_max_pulse", 32'(max_valid), 32'd0);
        check("basic_max_hold",  32'(max_data),  32'h7F);
        bwd_valid_in = 1'b1;
        bwd_data_in  = 8'h22;
        tick();
        bwd_valid_in = 1'b0;
        check("basic_bwd_valid", 32'(bwd_valid), 32'd1);
        check("basic_bwd_data",  32'(bwd_data),  32'h0022_0000);
        check("basic_bwd_level", 32'(level),     32'd0);
        check("basic_bwd_empty", 32'(bwd_ready), 32'd0);
        tick();
        check("basic_bwd_pulse", 32'(bwd_valid), 32'd0);
        check("basic_bwd_hold",  32'(bwd_data),  32'h0022_0000);

        // Signed compare with tie: lanes 1 and 2 both -1, lane 1 wins
        win(8'h80, 8'hFF, 8'hFF, 8'h80);
        fwd_valid = 1'b1;
        tick();
        fwd_valid = 1'b0;
        tick();
        check("tie_max_valid", 32'(max_valid), 32'd1);
        check("tie_max_data",  32'(max_data),  32'hFF);
        bwd_valid_in = 1'b1;
        bwd_data_in  = 8'h11;
        tick();
        bwd_valid_in = 1'b0;
        check("tie_bwd_data", 32'(bwd_data), 32'h0000_1100);

        // Full: four windows back-to-back, argmax lanes 3,0,1,2
        fwd_valid = 1'b1;
        win(8'h01, 8'h02, 8'h03, 8'h40);
        check("full_w0_ready", 32'(fwd_ready), 32'd1);
        tick();
        win(8'h50, 8'h02, 8'h03, 8'h04);
        check("full_w1_ready", 32'(fwd_ready), 32'd1);
        tick();
        win(8'hF0, 8'h60, 8'h03, 8'h60);
        check("full_w2_ready", 32'(fwd_ready), 32'd1);
        tick();
        win(8'h81, 8'h82, 8'h00, 8'hFF);
        check("full_w3_ready", 32'(fwd_ready), 32'd1);
        tick();
        win(8'h01, 8'h70, 8'h02, 8'h03);
        check("full_ready_low", 32'(fwd_ready), 32'd0);
        check("full_level3",    32'(level),     32'd3);
        tick();
        check("full_level4",     32'(level),     32'd4);
        check("full_still_low",  32'(fwd_ready), 32'd0);
        check("full_w3_max",     32'(max_data),  32'h00);
        bwd_valid_in = 1'b1;
        bwd_data_in  = 8'h33;
        tick();
        bwd_valid_in = 1'b0;
        check("full_pop_w0",     32'(bwd_data),  32'h3300_0000);
        check("full_ready_back", 32'(fwd_ready), 32'd1);
        check("full_pop_level",  32'(level),     32'd3);
        tick();
        fwd_valid = 1'b0;
        check("full_w4_taken", 32'(fwd_ready), 32'd0);
        tick();
        check("full_w4_max",   32'(max_data), 32'h70);
        check("full_level4b",  32'(level),    32'd4);
        bwd_valid_in = 1'b1;
        bwd_data_in  = 8'h41;
        tick();
        check("full_pop_w1", 32'(bwd_data), 32'h0000_0041);
        bwd_data_in = 8'h42;
        tick();
        check("full_pop_w2", 32'(bwd_data), 32'h0000_4200);
        bwd_data_in = 8'h43;
        tick();
        check("full_pop_w3", 32'(bwd_data), 32'h0043_0000);
        bwd_data_in = 8'h44;
        tick();
        bwd_valid_in = 1'b0;
        check("full_pop_w4",  32'(bwd_data),  32'h0000_4400);
        check("full_drained", 32'(level),     32'd0);
        check("full_empty",   32'(bwd_ready), 32'd0);

        // Simultaneous push and pop at level 2; argmax lanes 3,0,2
        fwd_valid = 1'b1;
        win(8'h01, 8'h02, 8'h03, 8'h04);
        tick();
        win(8'h09, 8'h02, 8'h03, 8'h04);
        tick();
        win(8'h01, 8'h02, 8'h09, 8'h04);
        tick();
        fwd_valid = 1'b0;
        check("sim_level_before", 32'(level), 32'd2);
        bwd_valid_in = 1'b1;
        bwd_data_in  = 8'h55;
        tick();
        bwd_valid_in = 1'b0;
        check("sim_level_after", 32'(level),     32'd2);
        check("sim_oldest",      32'(bwd_data),  32'h5500_0000);
        check("sim_max_valid",   32'(max_valid), 32'd1);
        check("sim_max_data",    32'(max_data),  32'h09);

        // Mid-operation reset at level 3 with stage 1 occupied
        fwd_valid = 1'b1;
        win(8'h01, 8'h02, 8'h03, 8'h04);
        tick();
        tick();
        fwd_valid = 1'b0;
        check("mid_level3", 32'(level),     32'd3);
        check("mid_ready0", 32'(fwd_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_level0",    32'(level),     32'd0);
        check("mid_bwd_ready", 32'(bwd_ready), 32'd0);
        check("mid_fwd_ready", 32'(fwd_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("mid_no_max_pulse", 32'(max_valid), 32'd0);
            check("mid_no_bwd_pulse", 32'(bwd_valid), 32'd0);
            check("mid_level_stays0", 32'(level),     32'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/svnet_max_unpool.md
Name: svnet_max_unpool

Overview:
- Backward/scatter counterpart of the max-pooling tree reducer.
- Forward side: accepts a COUNT-lane window, outputs the signed max, and records the winning lane index in an internal FIFO.
- Backward side: pops recorded indices in order and scatters each incoming WIDTH-bit value onto the recorded lane, zeroing all other lanes.
- Sits beside the pooling stage so unpooling reconstructs exact argmax positions.

Parameters:
- WIDTH, 8, lane data width, two's complement.
- COUNT, 4, lanes per window (>=1).
- DEPTH, 4, max outstanding argmax indices (>=2, power of two).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- i_fwd_valid  input  1  forward window valid.
- i_fwd_data  input  [COUNT-1:0][WIDTH-1:0]  forward window lanes.
- o_fwd_ready  output  1  forward window accepted when high with i_fwd_valid.
- o_max_valid  output  1  one-cycle pulse, pooled result valid.
- o_max_data  output  WIDTH  pooled signed max.
- i_bwd_valid  input  1  backward value valid.
- i_bwd_data  input  WIDTH  value to scatter.
- o_bwd_ready  output  1  index FIFO non-empty; backward value accepted when high with i_bwd_valid.
- o_bwd_valid  output  1  one-cycle pulse, scattered window valid.
- o_bwd_data  output  [COUNT-1:0][WIDTH-1:0]  scattered window.
- o_level  output  $clog2(DEPTH+1)  indices currently stored in the FIFO.

Behaviour:
- Reset: synchronous, active-high, on clk rising edge. All outputs, stage-1 registers, FIFO pointers and level go to 0. o_fwd_ready=1 and o_bwd_ready=0 in the first cycle after rst deasserts. Reset mid-operation discards every stored index and any in-flight window; no o_max_valid or o_bwd_valid follows for discarded work.
- Forward accept: i_fwd_valid & o_fwd_ready in cycle c; window registered at end of c (stage 1).
- Argmax: computed combinationally from stage 1 during c+1.
  - Signed compare.
  - Ties: lowest lane index wins.
- End of c+1: index pushed into FIFO; o_max_data registered.
- Cycle c+2: o_max_valid=1 for exactly one cycle.
- Forward latency: fixed at 2; back-to-back windows each cycle are allowed while ready.
- o_max_data holds its value when o_max_valid=0.
- o_fwd_ready = (o_level + stage1_valid) < DEPTH. A same-cycle pop is not credited (conservative). i_fwd_valid while ready=0 is ignored; the upstream block holds the window.
- Backward accept: i_bwd_valid & o_bwd_ready in cycle d; the FIFO head is read combinationally.
- End of d:
  - FIFO pops.
  - o_bwd_data[head] <= i_bwd_data; all other lanes <= 0.
- Cycle d+1: o_bwd_valid=1 for exactly one cycle. Backward latency: 1.
- o_bwd_data holds its value when o_bwd_valid=0.
- Same-edge push and pop: level unchanged, order preserved.
  - Push only: level+1. Pop only: level-1.
  - Empty FIFO: o_bwd_ready=0; pop impossible. A push into an empty FIFO is visible as o_bwd_ready=1 one cycle later; there is no bypass.
- Pointers wrap modulo DEPTH. Overflow is impossible by construction; an assertion checks that no push occurs at level==DEPTH.
- COUNT==1: index is always 0; max = lane 0; scatter passes through.

Decomposition:
- Shared package svnet_pkg:
  - function svnet_idx_width(count): returns 1 when count==1, else $clog2(count).
  - Signed max/argmax compare helper shared with the pooling tree.
- Sub-module svnet_index_fifo: DEPTH x idx_width synchronous FIFO with push, pop, head, level, and the same clk/rst.
- Argmax logic and scatter logic stay in svnet_max_unpool.

Test Plan:
- Reset: assert rst 2 cycles -> o_fwd_ready=1, o_bwd_ready=0, o_level=0, o_max_valid=0, o_bwd_valid=0, data outputs 0.
- Basic: lanes {0x05,0xFD,0x7F,0x10} accepted at c -> o_max_valid at c+2 with 0x7F, o_level=1. Then i_bwd_data=0x22 -> next cycle o_bwd_data lanes {0,0,0x22,0}, o_level=0.
- Signed/tie: lanes {0x80,0xFF,0xFF,0x80} -> o_max_data=0xFF. Scatter of 0x11 lands on lane 1 only.
- Full: four windows back-to-back with no backward traffic -> o_fwd_ready=0 once level+in-flight=4, and a held fifth window is not taken. One backward accept -> ready=1 the next cycle; fifth window accepted, indices popped in push order.
- Simultaneous: at o_level=2, a forward result lands on the same edge as a backward accept -> o_level stays 2. Scatter uses the oldest index.
- Mid-reset: o_level=3 with stage 1 valid, assert rst 1 cycle -> o_level=0, o_bwd_ready=0, no o_max_valid pulse afterwards.
